// File: rtl/spi_hle_pkg.sv
// Shared types and constants for the SPI high-level-emulation arbiter and its responders.
package spi_hle_pkg;

    localparam int unsigned FAULT_CNT_W   = 15;
    localparam logic [7:0]  SPI_IDLE_BYTE = 8'hFF;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } e_arb_state;

endpackage

// File: rtl/parallelel_spi.sv
// Parallel SPI byte channel between the CD-i slave processor and its byte handlers.
interface parallelel_spi;

    logic       write;
    logic [7:0] mosi;
    logic [7:0] miso;

    modport slave (
        input  write,
        input  mosi,
        output miso
    );

    modport master (
        output write,
        output mosi,
        input  miso
    );

endinterface

// File: rtl/mode_fault_timer.sv
// Mode-fault countdown: a nonzero load restarts the count, and a one-cycle pulse is
// registered from count==1, so load V at edge N pulses at edge N+V.
module mode_fault_timer
    import spi_hle_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [FAULT_CNT_W-1:0] load_val,
    output logic                   pulse
);

    logic [FAULT_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   pulse_q;

    always_comb begin
        fcnt_d = fcnt_q;
        if (load) begin
            fcnt_d = load_val;
        end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            pulse_q <= (fcnt_q == FAULT_CNT_W'(1));
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/spi_hle_arbiter.sv
// Shares the parallel SPI byte channel between two HLE responders, one frame owner at a time.
// Optional owner-idle watchdog enabled by defining SPI_HLE_ARB_WDOG_EN.
module spi_hle_arbiter
    import spi_hle_pkg::*;
#(
    parameter logic [FAULT_CNT_W-1:0] WDOG_CYCLES = 15'd4095,
    parameter int unsigned            RESP_COUNT  = 2
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    parallelel_spi.slave                             spi,
    output logic [RESP_COUNT-1:0]                    rsp_write,
    output logic [7:0]                               rsp_mosi,
    output logic                                     rsp_first,
    input  logic [RESP_COUNT-1:0][7:0]               rsp_miso,
    input  logic [RESP_COUNT-1:0]                    rsp_claim,
    input  logic [RESP_COUNT-1:0]                    rsp_release,
    input  logic [RESP_COUNT-1:0][FAULT_CNT_W-1:0]   rsp_fault_req,
    output logic                                     quirk_force_mode_fault,
    output logic [RESP_COUNT-1:0]                    owner
);

    e_arb_state              state_q, state_d;
    logic [RESP_COUNT-1:0]   owner_q, owner_d;
    logic                    rr_q, rr_d;
    logic                    grant;
    logic                    grant_idx;
    logic                    owner_idx;
    logic                    fault_load;
    logic [FAULT_CNT_W-1:0]  fault_val;
    logic                    wdog_expire;

    assign owner_idx = owner_q[1];
    assign rsp_mosi  = spi.mosi;
    assign owner     = owner_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        grant      = 1'b0;
        grant_idx  = rr_q;
        rsp_write  = '0;
        rsp_first  = 1'b0;
        spi.miso   = SPI_IDLE_BYTE;
        fault_load = 1'b0;
        fault_val  = rsp_fault_req[0];

        case (state_q)
            ARB_IDLE: begin
                rsp_first = 1'b1;
                if (spi.write) begin
                    rsp_write = '1;
                    case (rsp_claim)
                        2'b01: begin
                            grant     = 1'b1;
                            grant_idx = 1'b0;
                        end
                        2'b10: begin
                            grant     = 1'b1;
                            grant_idx = 1'b1;
                        end
                        2'b11: begin
                            // Contended frame start: pointer picks, then yields to the loser.
                            grant     = 1'b1;
                            grant_idx = rr_q;
                            rr_d      = ~rr_q;
                        end
                        default: ;
                    endcase
                    if (grant) begin
                        spi.miso   = rsp_miso[grant_idx];
                        state_d    = ARB_OWNED;
                        owner_d    = 2'b01 << grant_idx;
                        fault_val  = rsp_fault_req[grant_idx];
                        fault_load = (fault_val != '0);
                    end
                end
            end
            ARB_OWNED: begin
                if (spi.write) begin
                    rsp_write = owner_q;
                    spi.miso  = rsp_miso[owner_idx];
                end
                fault_val  = rsp_fault_req[owner_idx];
                fault_load = (fault_val != '0);
                if (((rsp_release & owner_q) != '0) || wdog_expire) begin
                    state_d = ARB_IDLE;
                    owner_d = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

`ifdef SPI_HLE_ARB_WDOG_EN
    logic [FAULT_CNT_W-1:0] wdog_q, wdog_d;

    // Counts consecutive silent owned cycles; any write or leaving ownership clears it.
    always_comb begin
        wdog_d      = '0;
        wdog_expire = 1'b0;
        if (state_q == ARB_OWNED && !spi.write) begin
            if (wdog_q == WDOG_CYCLES - 1'b1) begin
                wdog_expire = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_wdog_cycles;
    assign unused_wdog_cycles = ^WDOG_CYCLES;
    assign wdog_expire        = 1'b0;
`endif

    mode_fault_timer u_mode_fault_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (fault_load),
        .load_val (fault_val),
        .pulse    (quirk_force_mode_fault)
    );

endmodule

// File: tb/tb_spi_hle_arbiter.sv
// Self-checking bench for spi_hle_arbiter: directed frames plus random traffic against a
// frame-level reference model.
module tb_spi_hle_arbiter;

    localparam int WDOG = 100;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       rsp_write;
    logic [7:0]       rsp_mosi;
    logic             rsp_first;
    logic [1:0][7:0]  rsp_miso;
    logic [1:0]       rsp_claim;
    logic [1:0]       rsp_release;
    logic [1:0][14:0] rsp_fault_req;
    logic             pulse;
    logic [1:0]       owner;

    parallelel_spi spi_if ();

    spi_hle_arbiter #(
        .WDOG_CYCLES (15'd100),
        .RESP_COUNT  (2)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .spi                    (spi_if),
        .rsp_write              (rsp_write),
        .rsp_mosi               (rsp_mosi),
        .rsp_first              (rsp_first),
        .rsp_miso               (rsp_miso),
        .rsp_claim              (rsp_claim),
        .rsp_release            (rsp_release),
        .rsp_fault_req          (rsp_fault_req),
        .quirk_force_mode_fault (pulse),
        .owner                  (owner)
    );

    always #5 clk = ~clk;

    // Reference model: owning port (-1 = none), round-robin pick, edge of next pulse.
    int m_owner  = -1;
    int m_rr     = 0;
    int m_pend   = -1;
    int m_silent = 0;
    int edge_n   = 0;
    int errors   = 0;
    int checks   = 0;
    int pulse_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_owner();
        return (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    endfunction

    task automatic cyc(input logic w, input logic [7:0] mosi, input logic [1:0] claim,
                       input logic [1:0] rel, input logic [14:0] f0, input logic [14:0] f1,
                       input logic [7:0] m0, input logic [7:0] m1);
        logic       grant;
        int         g;
        int         src;
        int         fv;
        logic [1:0] exp_wr;
        logic [7:0] exp_miso;
        logic       exp_pulse;
        spi_if.write     = w;
        spi_if.mosi      = mosi;
        rsp_claim        = claim;
        rsp_release      = rel;
        rsp_fault_req[0] = f0;
        rsp_fault_req[1] = f1;
        rsp_miso[0]      = m0;
        rsp_miso[1]      = m1;
        #1;
        grant    = 1'b0;
        g        = m_rr;
        exp_wr   = 2'b00;
        exp_miso = 8'hFF;
        if (m_owner < 0) begin
            if (w) begin
                exp_wr = 2'b11;
                if (claim == 2'b01) begin grant = 1'b1; g = 0; end
                else if (claim == 2'b10) begin grant = 1'b1; g = 1; end
                else if (claim == 2'b11) begin grant = 1'b1; g = m_rr; end
                if (grant) exp_miso = (g == 0) ? m0 : m1;
            end
        end else if (w) begin
            exp_wr   = exp_owner();
            exp_miso = (m_owner == 0) ? m0 : m1;
        end
        check("miso", 32'(spi_if.miso), 32'(exp_miso));
        check("rsp_write", 32'(rsp_write), 32'(exp_wr));
        check("rsp_first", 32'(rsp_first), 32'(m_owner < 0));
        check("rsp_mosi", 32'(rsp_mosi), 32'(mosi));
        @(posedge clk);
        edge_n++;
        exp_pulse = (m_pend == edge_n);
        src = (m_owner < 0) ? (grant ? g : -1) : m_owner;
        if (src >= 0) begin
            fv = (src == 0) ? int'(f0) : int'(f1);
            if (fv != 0) m_pend = edge_n + fv;
        end
        if (m_owner < 0) begin
            if (grant) begin
                if (claim == 2'b11) m_rr = 1 - g;
                m_owner  = g;
                m_silent = 0;
            end
        end else if (rel[m_owner]) begin
            m_owner = -1;
        end else if (w) begin
            m_silent = 0;
        end else begin
            m_silent++;
`ifdef SPI_HLE_ARB_WDOG_EN
            if (m_silent == WDOG) m_owner = -1;
`endif
        end
        #1;
        check("owner", 32'(owner), 32'(exp_owner()));
        check("pulse", 32'(pulse), 32'(exp_pulse));
        if (pulse) pulse_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 2'b00, 2'b00, 15'd0, 15'd0, 8'h3C, 8'hC3);
    endtask

    initial begin
        reset_n          = 1'b0;
        spi_if.write     = 1'b0;
        spi_if.mosi      = 8'h00;
        rsp_claim        = 2'b00;
        rsp_release      = 2'b00;
        rsp_fault_req[0] = '0;
        rsp_fault_req[1] = '0;
        rsp_miso[0]      = 8'h00;
        rsp_miso[1]      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_owner", 32'(owner), 32'd0);
        check("reset_pulse", 32'(pulse), 32'd0);
        check("reset_miso", 32'(spi_if.miso), 32'hFF);
        check("reset_rsp_write", 32'(rsp_write), 32'd0);
        reset_n = 1'b1;

        // Port 0 claims the frame start byte.
        cyc(1'b1, 8'hB0, 2'b01, 2'b00, 15'd0, 15'd0, 8'h55, 8'hAA);
        check("claim_owner", 32'(owner), 32'h1);
        cyc(1'b1, 8'h01, 2'b10, 2'b00, 15'd0, 15'd0, 8'h66, 8'h77);
        // Non-owner fault request and release are ignored.
        cyc(1'b0, 8'h00, 2'b00, 2'b10, 15'd0, 15'd5, 8'h00, 8'h00);
        check("nonowner_release", 32'(owner), 32'h1);
        // Release together with a write: byte still reaches the owner.
        cyc(1'b1, 8'h02, 2'b00, 2'b01, 15'd0, 15'd0, 8'h88, 8'h99);
        idle(8);
        // Unclaimed frame start.
        cyc(1'b1, 8'h12, 2'b00, 2'b00, 15'd0, 15'd0, 8'h11, 8'h22);
        idle(2);
        // Contended frames alternate.
        cyc(1'b1, 8'hC0, 2'b11, 2'b00, 15'd0, 15'd0, 8'hA0, 8'hA1);
        check("rr_first", 32'(owner), 32'h1);
        cyc(1'b0, 8'h00, 2'b00, 2'b01, 15'd0, 15'd0, 8'h00, 8'h00);
        cyc(1'b1, 8'hC1, 2'b11, 2'b00, 15'd0, 15'd0, 8'hB0, 8'hB1);
        check("rr_second", 32'(owner), 32'h2);
        // Fault load 80, reload 80 forty edges later: exactly one pulse.
        pulse_seen = 0;
        cyc(1'b1, 8'h20, 2'b00, 2'b00, 15'd0, 15'd80, 8'h00, 8'h01);
        idle(39);
        cyc(1'b1, 8'h21, 2'b00, 2'b00, 15'd0, 15'd80, 8'h00, 8'h02);
        idle(125);
        check("fault_pulse_count", 32'(pulse_seen), 32'd1);
        cyc(1'b0, 8'h00, 2'b00, 2'b11, 15'd0, 15'd0, 8'h00, 8'h00);
        // Silent owner.
        cyc(1'b1, 8'hD0, 2'b01, 2'b00, 15'd0, 15'd0, 8'h42, 8'h24);
        idle(150);
`ifdef SPI_HLE_ARB_WDOG_EN
        check("wdog_release", 32'(owner), 32'd0);
`else
        check("no_wdog_hold", 32'(owner), 32'h1);
`endif
        cyc(1'b0, 8'h00, 2'b00, 2'b01, 15'd0, 15'd0, 8'h00, 8'h00);

        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom % 2), 8'($urandom), 2'($urandom),
                ($urandom % 6 == 0) ? 2'($urandom) : 2'b00,
                ($urandom % 10 == 0) ? 15'($urandom_range(1, 30)) : 15'd0,
                ($urandom % 10 == 0) ? 15'($urandom_range(1, 30)) : 15'd0,
                8'($urandom), 8'($urandom));
        end
        idle(40);

        // Reset mid-frame with a pending fault count.
        cyc(1'b0, 8'h00, 2'b00, 2'b11, 15'd0, 15'd0, 8'h00, 8'h00);
        cyc(1'b1, 8'hE0, 2'b10, 2'b00, 15'd0, 15'd20, 8'h10, 8'h20);
        cyc(1'b1, 8'hE1, 2'b00, 2'b00, 15'd0, 15'd0, 8'h10, 8'h20);
        spi_if.write = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_owner", 32'(owner), 32'd0);
        check("async_reset_first", 32'(rsp_first), 32'd1);
        check("async_reset_miso", 32'(spi_if.miso), 32'hFF);
        check("async_reset_pulse", 32'(pulse), 32'd0);
        m_owner  = -1;
        m_rr     = 0;
        m_pend   = -1;
        m_silent = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulse_seen = 0;
        idle(30);
        check("no_pulse_after_reset", 32'(pulse_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
